// File: rtl/temp_ctrl_pkg.sv
// Shared types and default timing for the zone HVAC arbiter.
package temp_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, HEAT, COOL, DEAD} arb_state_t;
  typedef enum logic {HEAT_MODE, COOL_MODE} hvac_mode_t;

  localparam int DEF_N_ZONES       = 4;
  localparam int DEF_MIN_ON_CYCLES = 16;
  localparam int DEF_MAX_ON_CYCLES = 64;
  localparam int DEF_DEAD_CYCLES   = 8;

endpackage

// File: rtl/zone_hvac_arbiter_picker.sv
// Rotating-priority search: first set bit of valid at or after rr_ptr, wrapping.
module rr_zone_picker #(
  parameter int N_ZONES = 4,
  parameter int IW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
  input  logic [N_ZONES-1:0] valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic               found,
  output logic [IW-1:0]      index
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N_ZONES - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_ZONES;
      if (valid[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/zone_hvac_arbiter.sv
// Round-robin sharing of one heater/cooler between thermostat zones with
// min/max on-time and dead time between grants.
module zone_hvac_arbiter
  import temp_ctrl_pkg::*;
#(
  parameter int N_ZONES       = DEF_N_ZONES,
  parameter int MIN_ON_CYCLES = DEF_MIN_ON_CYCLES,
  parameter int MAX_ON_CYCLES = DEF_MAX_ON_CYCLES,
  parameter int DEAD_CYCLES   = DEF_DEAD_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ZONES-1:0] heat_req,
  input  logic [N_ZONES-1:0] cool_req,
  output logic               heater_on,
  output logic               cooler_on,
  output logic [N_ZONES-1:0] zone_grant,
  output logic [N_ZONES-1:0] req_conflict,
  output logic               busy
);

  localparam int CW = $clog2(MAX_ON_CYCLES);
  localparam int IW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_ON_CYCLES - 1);
  localparam logic [CW-1:0] MAX_LAST  = CW'(MAX_ON_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_ZONE = IW'(N_ZONES - 1);
  localparam logic [N_ZONES-1:0] ONE  = N_ZONES'(1);

  arb_state_t       state, state_n;
  logic [IW-1:0]    g, g_n, rr_ptr, rr_n, pick_idx;
  logic [CW-1:0]    cnt, cnt_n;
  logic [N_ZONES-1:0] valid, g_onehot;
  logic             pick_found, own_req, others_wait;
  hvac_mode_t       pick_mode;

  // A zone asking for both at once is treated as not asking at all.
  assign req_conflict = heat_req & cool_req;
  assign valid        = heat_req ^ cool_req;
  assign g_onehot     = ONE << g;
  assign others_wait  = |(valid & ~g_onehot);
  assign own_req      = valid[g] & ((state == HEAT) ? heat_req[g] : cool_req[g]);
  assign pick_mode    = heat_req[pick_idx] ? HEAT_MODE : COOL_MODE;

  rr_zone_picker #(.N_ZONES(N_ZONES), .IW(IW)) u_pick (
    .valid (valid),
    .rr_ptr(rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      g      <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_n;
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          g_n     = pick_idx;
          cnt_n   = '0;
          state_n = (pick_mode == HEAT_MODE) ? HEAT : COOL;
          rr_n    = (pick_idx == LAST_ZONE) ? '0 : pick_idx + 1'b1;
        end
      end
      HEAT, COOL: begin
        // Dropping before min on-time keeps the compressor running.
        if ((cnt >= MIN_LAST && !own_req) || (cnt == MAX_LAST && others_wait)) begin
          state_n = DEAD;
          cnt_n   = '0;
        end else if (cnt != MAX_LAST) begin
          cnt_n = cnt + 1'b1;
        end
      end
      DEAD: begin
        if (cnt == DEAD_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign heater_on  = (state == HEAT);
  assign cooler_on  = (state == COOL);
  assign zone_grant = (state == HEAT || state == COOL) ? g_onehot : '0;
  assign busy       = (state != IDLE);

endmodule

// File: doc/zone_hvac_arbiter.md
Name: zone_hvac_arbiter

Overview:
- Shares one heater and one cooler (a single HVAC unit) between N_ZONES per-zone thermostat FSMs.
- Each zone's heater_on/cooler_on outputs arrive here as heat_req/cool_req.
- The arbiter grants one zone at a time, round-robin. It opens that zone's damper (zone_grant) and drives the shared actuator.
- Enforces minimum on-time, maximum on-time when other zones are waiting, and a dead time between every grant.

Parameters:
- N_ZONES, 4, number of requesting zones (2..16).
- MIN_ON_CYCLES, 16, minimum cycles an actuator stays on once granted (>=1).
- MAX_ON_CYCLES, 64, on-time after which the grant is released if another zone waits (>MIN_ON_CYCLES).
- DEAD_CYCLES, 8, all-off settle cycles after every release (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- heat_req  in  N_ZONES  per-zone heating request, level
- cool_req  in  N_ZONES  per-zone cooling request, level
- heater_on  out  1  shared heater enable
- cooler_on  out  1  shared cooler enable
- zone_grant  out  N_ZONES  one-hot damper open, all-zero when no grant
- req_conflict  out  N_ZONES  zone asserting heat_req and cool_req together
- busy  out  1  state is not IDLE

Behaviour:
- One clock; reset is asynchronous and active-high. All state is clocked on posedge clk.
- Reset (including mid-grant): state=IDLE, heater_on=0, cooler_on=0, zone_grant=0, busy=0, counter=0, rr_ptr=0.
- req_conflict is the same-cycle combinational AND of heat_req and cool_req. It reads 0 during reset only if inputs are 0.
- Valid request for zone i: exactly one of heat_req[i] and cool_req[i] is set. Conflicting zones are ignored by arbitration.
- States are IDLE, HEAT, COOL and DEAD. Outputs decode directly from registered state, granted index and mode, so they have no extra pipeline stage:
  - HEAT: heater_on=1, zone_grant=onehot(g).
  - COOL: cooler_on=1, zone_grant=onehot(g).
  - IDLE and DEAD: all outputs off.
- IDLE:
  - Search zones rr_ptr, rr_ptr+1, … mod N for the first valid request.
  - If found: g is latched, counter is cleared, and the next state is HEAT or COOL according to that zone's request. rr_ptr <= (g+1) mod N.
  - If none: stay in IDLE.
  - Latency: a request sampled at edge k produces the actuator on after edge k.
- HEAT/COOL:
  - The counter increments each cycle and saturates at MAX_ON_CYCLES-1.
  - own_req = heat_req[g] in HEAT, cool_req[g] in COOL. Conflict counts as deasserted.
  - others_wait = any valid request from a zone other than g.
  - Release to DEAD when (counter >= MIN_ON_CYCLES-1 and !own_req), or when (counter == MAX_ON_CYCLES-1 and others_wait).
  - If own_req drops before MIN_ON is satisfied, the actuator stays on (compressor protection).
  - At MAX with no other waiter, the grant continues indefinitely.
  - A zone flipping from heat to cool while granted is treated as release. It re-arbitrates after DEAD.
- DEAD:
  - On entry the counter clears. Stay DEAD_CYCLES cycles, then go to IDLE.
  - Every grant change costs at least DEAD_CYCLES+1 all-off cycles (DEAD plus the IDLE arbitration cycle).
- heater_on and cooler_on are never both 1. zone_grant has at most one bit set.
- Counter width is $clog2(MAX_ON_CYCLES) bits, which also covers DEAD_CYCLES (DEAD_CYCLES must be < MAX_ON_CYCLES).

Decomposition:
- Package temp_ctrl_pkg:
  - state enum arb_state_t {IDLE, HEAT, COOL, DEAD}
  - mode type (HEAT_MODE/COOL_MODE)
  - default timing constants
- Sub-module rr_zone_picker, parameterised by N_ZONES:
  - Combinational rotate-priority search.
  - Inputs: valid vector, rr_ptr.
  - Outputs: found, index.

Test Plan (bench params N_ZONES=4, MIN_ON=4, MAX_ON=8, DEAD=2):
1. Reset, then heat_req=4'b0100 held -> after 1st edge heater_on=1, zone_grant=4'b0100. Drop heat_req after 1 cycle -> heater stays on for 4 total cycles, then 2 DEAD cycles and 1 IDLE cycle all-off.
2. cool_req=4'b0001 and heat_req=4'b1000 both held -> zone0 cools for 8 cycles; preempt; 3 off cycles; zone3 heats for 8 cycles; back to zone0. The round-robin alternation holds over 4 rotations.
3. heat_req=4'b0010 held alone for 30 cycles -> continuous grant, no preemption, counter saturates, heater_on stays 1.
4. heat_req[1]=cool_req[1]=1 with zone 2 heating -> req_conflict=4'b0010. Zone 1 is never granted while zone 2 is served.
5. Assert reset mid-COOL at counter=5 -> all outputs 0 asynchronously. After release, rr_ptr=0, so zone0 wins over zone3 when both request.
6. Granted zone 2 switches from heat_req to cool_req at counter=5 -> DEAD 2 cycles, IDLE, then cooler_on=1 with zone_grant=4'b0100 if no other requester lies ahead in rr order.
